// File: rtl/vga_tile_renderer_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg
// RGB332 colour constants and default 640x480@60 VGA timing.
// Rev 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam rgb332_t BLACK = 8'h00;
    localparam rgb332_t WHITE = 8'hFF;
    localparam rgb332_t RED   = 8'hE0;
    localparam rgb332_t GREEN = 8'h1C;
    localparam rgb332_t FLOOR = 8'h25;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage
`default_nettype wire

// File: rtl/vga_tile_renderer_timing.sv
`default_nettype none
// ============================================================================
// vga_timing
// Pixel-enable divider, h/v raster counters, raw sync/blank and frame_start.
// Rev 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = 4,
    localparam int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          o_pe,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_h_sync_act,
    output logic          o_v_sync_act,
    output logic          o_blank,
    output logic          o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] c_DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] c_H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_HS_ON   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_HS_OFF  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] c_V_MAX   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] c_VS_ON   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_VS_OFF  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_pe;
    logic          w_h_wrap;

    assign w_pe     = (r_div == c_DIV_MAX);
    assign w_h_wrap = (r_h == c_H_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_pe ? '0 : r_div + DW'(1);
            if (w_pe) begin
                r_h <= w_h_wrap ? '0 : r_h + HW'(1);
                if (w_h_wrap) begin
                    r_v <= (r_v == c_V_MAX) ? '0 : r_v + VW'(1);
                end
            end
        end
    end

    assign o_pe          = w_pe;
    assign o_h_cnt       = r_h;
    assign o_v_cnt       = r_v;
    assign o_h_sync_act  = (r_h >= c_HS_ON) && (r_h < c_HS_OFF);
    assign o_v_sync_act  = (r_v >= c_VS_ON) && (r_v < c_VS_OFF);
    assign o_blank       = (r_h >= c_H_ACT) || (r_v >= c_V_ACT);
    // First pixel period of the vertical blank; exactly one clk wide
    assign o_frame_start = w_pe && (r_h == '0) && (r_v == c_V_ACT);

endmodule
`default_nettype wire

// File: rtl/vga_tile_renderer.sv
`default_nettype none
// ============================================================================
// vga_tile_renderer
// VGA timing plus a two-stage tile-map renderer driving RGB332 pins.
// Optional macro PLAYER_BLINK_EN: blink the player tile every 32 frames.
// Rev 1.0 - initial release
// ============================================================================
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int SYNC_POL  = 0,
    parameter int CLK_DIV   = 4,
    parameter int TILE_LOG2 = 4,
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int GRID_X0   = 192,
    parameter int GRID_Y0   = 112,
    localparam int XW       = $clog2(GRID_W),
    localparam int YW       = $clog2(GRID_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [YW+XW-1:0] player_pos,
    input  logic [YW+XW-1:0] goal_pos,
    output logic [YW+XW-1:0] tile_addr,
    input  logic             tile_wall,
    output logic             frame_start,
    output logic             vga_h_sync,
    output logic             vga_v_sync,
    output logic [2:0]       vga_r,
    output logic [2:0]       vga_g,
    output logic [1:0]       vga_b
);

    localparam int AW = YW + XW;
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    localparam logic [HW-1:0] c_GX0     = HW'(GRID_X0);
    localparam logic [HW-1:0] c_GX1     = HW'(GRID_X0 + (GRID_W << TILE_LOG2));
    localparam logic [VW-1:0] c_GY0     = VW'(GRID_Y0);
    localparam logic [VW-1:0] c_GY1     = VW'(GRID_Y0 + (GRID_H << TILE_LOG2));
    localparam logic          c_SYNC_ON = (SYNC_POL != 0);

    logic          w_pe;
    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_blank;
    logic          w_frame_start;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk           (clk),
        .reset         (reset),
        .o_pe          (w_pe),
        .o_h_cnt       (w_h),
        .o_v_cnt       (w_v),
        .o_h_sync_act  (w_hs_act),
        .o_v_sync_act  (w_vs_act),
        .o_blank       (w_blank),
        .o_frame_start (w_frame_start)
    );

    // ---- S1: grid hit test and tile address --------------------------------
    logic [HW-1:0] w_h_off;
    logic [VW-1:0] w_v_off;
    logic [XW-1:0] w_col;
    logic [YW-1:0] w_row;
    logic          w_in_grid;

    assign w_h_off   = w_h - c_GX0;
    assign w_v_off   = w_v - c_GY0;
    assign w_col     = XW'(w_h_off >> TILE_LOG2);
    assign w_row     = YW'(w_v_off >> TILE_LOG2);
    assign w_in_grid = (w_h >= c_GX0) && (w_h < c_GX1) &&
                       (w_v >= c_GY0) && (w_v < c_GY1);

    logic          r_s1_blank;
    logic          r_s1_hs_act;
    logic          r_s1_vs_act;
    logic          r_s1_in_grid;
    logic [AW-1:0] r_tile_addr;
    logic [AW-1:0] r_player;
    logic [AW-1:0] r_goal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_blank   <= 1'b0;
            r_s1_hs_act  <= 1'b0;
            r_s1_vs_act  <= 1'b0;
            r_s1_in_grid <= 1'b0;
            r_tile_addr  <= '0;
        end else if (w_pe) begin
            r_s1_blank   <= w_blank;
            r_s1_hs_act  <= w_hs_act;
            r_s1_vs_act  <= w_vs_act;
            r_s1_in_grid <= w_in_grid;
            if (w_in_grid) begin
                r_tile_addr <= {w_row, w_col};
            end
        end
    end

    // Positions are sampled only in vertical blank so a frame never tears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_player <= '0;
            r_goal   <= '0;
        end else if (w_frame_start) begin
            r_player <= player_pos;
            r_goal   <= goal_pos;
        end
    end

    logic w_player_vis;

`ifdef PLAYER_BLINK_EN
    logic [5:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    assign w_player_vis = ~r_frame_cnt[5];
`else
    assign w_player_vis = 1'b1;
`endif

    // ---- S2: colour select and pin registers -------------------------------
    rgb332_t w_colour;
    rgb332_t r_rgb;
    logic    r_h_sync;
    logic    r_v_sync;

    always_comb begin
        w_colour = BLACK;
        if (r_s1_blank || !r_s1_in_grid) begin
            w_colour = BLACK;
        end else if (w_player_vis && (r_tile_addr == r_player)) begin
            w_colour = RED;
        end else if (r_tile_addr == r_goal) begin
            w_colour = GREEN;
        end else if (tile_wall) begin
            w_colour = WHITE;
        end else begin
            w_colour = FLOOR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb    <= BLACK;
            r_h_sync <= ~c_SYNC_ON;
            r_v_sync <= ~c_SYNC_ON;
        end else if (w_pe) begin
            r_rgb    <= w_colour;
            r_h_sync <= r_s1_hs_act ? c_SYNC_ON : ~c_SYNC_ON;
            r_v_sync <= r_s1_vs_act ? c_SYNC_ON : ~c_SYNC_ON;
        end
    end

    assign tile_addr   = r_tile_addr;
    assign frame_start = w_frame_start;
    assign vga_h_sync  = r_h_sync;
    assign vga_v_sync  = r_v_sync;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vga_tile_renderer
// Small-raster bench: table of pixel probes, mid-frame moves, random maps.
// Rev 1.0 - initial release
// ============================================================================
module tb_vga_tile_renderer;

    localparam int HA = 48, HFP = 2, HSW = 4, HBP = 2, HT = HA + HFP + HSW + HBP;
    localparam int VA = 40, VFP = 1, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
    localparam int D = 2, TL = 2, GW = 8, GH = 8, GX0 = 8, GY0 = 4;
    localparam int TILE = 1 << TL;
    localparam int FRAME_CLK = HT * VT * D;
    localparam int MAX_FAILS = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] player_pos = 6'h00;
    logic [5:0] goal_pos = 6'h00;
    logic [5:0] tile_addr;
    logic       tile_wall;
    logic       frame_start;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;

    logic       wall_ones = 1'b1;
    logic       wall_mem [64];
    int         checks = 0;
    int         failures = 0;
    int unsigned cyc;

    assign tile_wall = wall_ones ? 1'b1 : wall_mem[tile_addr];

    vga_tile_renderer #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .SYNC_POL (0), .CLK_DIV (D), .TILE_LOG2 (TL),
        .GRID_W (GW), .GRID_H (GH), .GRID_X0 (GX0), .GRID_Y0 (GY0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .player_pos  (player_pos),
        .goal_pos    (goal_pos),
        .tile_addr   (tile_addr),
        .tile_wall   (tile_wall),
        .frame_start (frame_start),
        .vga_h_sync  (vga_h_sync),
        .vga_v_sync  (vga_v_sync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
            if (failures >= MAX_FAILS) finish_tb();
        end
    endtask

    function automatic logic [16:0] pins();
        return {vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_start, tile_addr};
    endfunction

    // ---- reference model ---------------------------------------------------
    logic [5:0] m_player = 6'h00;
    logic [5:0] m_goal = 6'h00;
    logic [5:0] m_addr = 6'h00;
    int         m_last_p = 0;
    int         m_frames = 0;

    function automatic bit in_grid(input int h, input int v);
        return (h >= GX0) && (h < GX0 + GW * TILE) && (v >= GY0) && (v < GY0 + GH * TILE);
    endfunction

    function automatic logic [5:0] addr_of(input int h, input int v);
        return 6'(((v - GY0) / TILE) * GW + (h - GX0) / TILE);
    endfunction

    function automatic logic [7:0] exp_colour(input int h, input int v);
        logic [5:0] a;
        bit vis;
`ifdef PLAYER_BLINK_EN
        vis = (m_frames % 64) < 32;
`else
        vis = 1'b1;
`endif
        if (h >= HA || v >= VA || !in_grid(h, v)) return 8'h00;
        a = addr_of(h, v);
        if (vis && a == m_player) return 8'hE0;
        if (a == m_goal) return 8'h1C;
        if (wall_ones || wall_mem[a]) return 8'hFF;
        return 8'h25;
    endfunction

    // Every clk: pins show pixel (p-2), tile_addr the last in-grid pixel below p
    always @(negedge clk) begin
        int p, dv, hp, vp, q, hq, vq;
        logic [7:0] e_rgb;
        logic e_hs, e_vs, e_fs;
        if (!reset) begin
            m_player = 6'h00;
            m_goal   = 6'h00;
            m_addr   = 6'h00;
            m_last_p = 0;
            m_frames = 0;
            check("sb_reset", 32'(pins()), 32'({8'h00, 1'b1, 1'b1, 1'b0, 6'h00}));
        end else begin
            p  = int'(cyc) / D;
            dv = int'(cyc) % D;
            hp = p % HT;
            vp = (p / HT) % VT;
            if (p > m_last_p) begin
                q  = p - 1;
                hq = q % HT;
                vq = (q / HT) % VT;
                if (in_grid(hq, vq)) m_addr = addr_of(hq, vq);
                m_last_p = p;
            end
            e_fs = (dv == D - 1) && (hp == 0) && (vp == VA);
            if (p >= 2) begin
                q     = p - 2;
                hq    = q % HT;
                vq    = (q / HT) % VT;
                e_rgb = exp_colour(hq, vq);
                e_hs  = !((hq >= HA + HFP) && (hq < HA + HFP + HSW));
                e_vs  = !((vq >= VA + VFP) && (vq < VA + VFP + VSW));
            end else begin
                e_rgb = 8'h00;
                e_hs  = 1'b1;
                e_vs  = 1'b1;
            end
            check("scoreboard", 32'(pins()), 32'({e_rgb, e_hs, e_vs, e_fs, m_addr}));
            if (e_fs) begin
                m_player = player_pos;
                m_goal   = goal_pos;
                m_frames++;
            end
        end
    end

    // ---- stimulus helpers --------------------------------------------------
    task automatic set_pos(input logic [5:0] p, input logic [5:0] g);
        @(posedge clk);
        #1;
        player_pos = p;
        goal_pos   = g;
    endtask

    task automatic wait_frame();
        bit ok = 1'b0;
        for (int i = 0; i < FRAME_CLK + 16; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_start_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_pixel(input int h, input int v);
        bit ok = 1'b0;
        int p, q;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge clk);
            p = int'(cyc) / D;
            if (p >= 2) begin
                q = p - 2;
                if ((q % HT == h) && ((q / HT) % VT == v)) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        check("pixel_reached", 32'(ok), 32'd1);
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [7:0] rgb);
        wait_pixel(h, v);
        check(name, 32'({vga_r, vga_g, vga_b}), 32'(rgb));
    endtask

    typedef struct {
        logic [5:0] player;
        logic [5:0] goal;
        int         h;
        int         v;
        logic [7:0] rgb;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        finish_tb();
    end

    initial begin
        logic [11:0] prev_key;
        bit          have_prev;

        for (int i = 0; i < 64; i++) wall_mem[i] = 1'b0;

        // player, goal, h, v, expected RGB332 (walls everywhere)
        vecs[0]  = '{6'h00, 6'h3F,  3,  2, 8'h00};   // outside grid
        vecs[1]  = '{6'h00, 6'h3F,  7,  4, 8'h00};   // one left of grid
        vecs[2]  = '{6'h00, 6'h3F,  8,  4, 8'hE0};   // grid origin, player
        vecs[3]  = '{6'h00, 6'h3F, 40,  4, 8'h00};   // one right of grid
        vecs[4]  = '{6'h00, 6'h3F, 50,  6, 8'h00};   // horizontal blank
        vecs[5]  = '{6'h00, 6'h3F, 12, 16, 8'hFF};   // wall tile 0x19
        vecs[6]  = '{6'h00, 6'h3F, 39, 35, 8'h1C};   // last grid pixel, goal
        vecs[7]  = '{6'h00, 6'h3F,  8, 36, 8'h00};   // one below grid
        vecs[8]  = '{6'h09, 6'h09, 12,  8, 8'hE0};   // player beats goal
        vecs[9]  = '{6'h12, 6'h09, 12,  8, 8'h1C};   // goal tile
        vecs[10] = '{6'h12, 6'h09, 16,  8, 8'hFF};   // tile 0x0A wall
        vecs[11] = '{6'h12, 6'h09, 16, 12, 8'hE0};   // player tile 0x12

        #50;
        check("reset_hold", 32'(pins()), 32'({8'h00, 1'b1, 1'b1, 1'b0, 6'h00}));
        #50;
        reset = 1'b1;

        have_prev = 1'b0;
        prev_key  = '0;
        for (int i = 0; i < 12; i++) begin
            if (!have_prev || prev_key != {vecs[i].player, vecs[i].goal}) begin
                set_pos(vecs[i].player, vecs[i].goal);
                wait_frame();
                prev_key  = {vecs[i].player, vecs[i].goal};
                have_prev = 1'b1;
            end
            probe($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].rgb);
        end

        // Mid-frame move must not show until the next frame
        set_pos(6'h00, 6'h3F);
        wait_frame();
        probe("move_pre", 8, 4, 8'hE0);
        set_pos(6'h11, 6'h3F);
        probe("move_old_tile", 9, 5, 8'hE0);
        probe("move_new_early", 12, 12, 8'hFF);
        wait_frame();
        probe("move_old_cleared", 8, 4, 8'hFF);
        probe("move_new_tile", 12, 12, 8'hE0);

        // Random wall maps with positions changed mid-frame
        for (int f = 0; f < 2; f++) begin
            wait_frame();
            wall_ones = 1'b0;
            for (int i = 0; i < 64; i++) wall_mem[i] = 1'($urandom_range(0, 1));
            set_pos(6'($urandom), 6'($urandom));
            repeat ($urandom_range(FRAME_CLK / 4, FRAME_CLK / 2)) @(posedge clk);
            #1;
            player_pos = 6'($urandom);
            goal_pos   = 6'($urandom);
        end

        // Asynchronous reset in the middle of a drawn line
        wait_pixel(20, 20);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", 32'(pins()), 32'({8'h00, 1'b1, 1'b1, 1'b0, 6'h00}));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_frame();
        probe("after_reset", 20, 20, (wall_mem[6'h23] ? 8'hFF : 8'h25));

        finish_tb();
    end

endmodule
`default_nettype wire
